// File: rtl/rv32_pipeline_pkg.sv
// Shared types for the pipelined RV32 core's memory-side blocks.
//   arb_state_e : memory arbiter sequencing state (IDLE -> REQ -> RESP)
//   arb_owner_e : which requester owns the in-flight memory transaction
//   STARVE_W    : width of the fetch anti-starvation counter (limit 1..15)
package rv32_pipeline_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DATA = 2'd2
  } arb_owner_e;

  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/pl_rv32_arb_select.sv
// Combinational priority chooser for the unified memory port.
// Data side wins by default; fetch wins once it has lost STARVE_LIMIT
// arbitrations in a row. A fetch request accompanied by if_flush is stale
// and is treated as absent (it neither wins nor counts as waiting).
// Ports:
//   if_req_i, d_req_i    : raw requests
//   if_flush_i           : fetch flush, masks the fetch request
//   starve_cnt_i         : consecutive fetch losses so far
//   if_gnt_o, d_gnt_o    : one-hot (or zero) grant decision
module pl_rv32_arb_select
  import rv32_pipeline_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                if_req_i,
  input  logic                d_req_i,
  input  logic                if_flush_i,
  input  logic [STARVE_W-1:0] starve_cnt_i,
  output logic                if_gnt_o,
  output logic                d_gnt_o
);

  logic if_live;
  logic if_starved;

  assign if_live    = if_req_i & ~if_flush_i;
  assign if_starved = if_live & (starve_cnt_i == STARVE_W'(STARVE_LIMIT));
  assign d_gnt_o    = d_req_i & ~if_starved;
  assign if_gnt_o   = if_live & ~d_gnt_o;

endmodule

// File: rtl/pl_rv32_mem_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// One transaction is outstanding at a time, sequenced IDLE -> REQ -> RESP.
//
// Handshakes (all requesters and the memory follow the same rules):
//   - if_req/d_req are held with stable fields until the matching gnt pulse;
//     gnt is combinational in the IDLE cycle the request wins.
//   - mem_req is registered and holds mem_* fields stable until a cycle with
//     mem_ready=1 (which may be the first mem_req cycle); it drops next cycle.
//   - exactly one mem_rvalid is expected per accepted request, in RESP; it is
//     forwarded combinationally to the owner's rvalid (fetch responses are
//     suppressed after an if_flush). mem_rvalid outside RESP sets the sticky
//     protocol_err.
//
// Ports: clk/rst_n; fetch side if_*; data side d_*; memory side mem_*;
//   protocol_err; dbg_state/dbg_owner/dbg_starve_cnt expose internal state.
// STARVE_LIMIT legal range is 1..15.
module pl_rv32_mem_arbiter
  import rv32_pipeline_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                protocol_err,
  output logic [1:0]          dbg_state,
  output logic [1:0]          dbg_owner,
  output logic [STARVE_W-1:0] dbg_starve_cnt
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic                drop_q, drop_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                perr_q, perr_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;

  logic sel_if_gnt;
  logic sel_d_gnt;
  logic if_live;

  assign if_live = if_req & ~if_flush;

  pl_rv32_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_select (
    .if_req_i     (if_req),
    .d_req_i      (d_req),
    .if_flush_i   (if_flush),
    .starve_cnt_i (starve_q),
    .if_gnt_o     (sel_if_gnt),
    .d_gnt_o      (sel_d_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_NONE;
      drop_q      <= 1'b0;
      starve_q    <= '0;
      perr_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      starve_q    <= starve_d;
      perr_q      <= perr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    starve_d    = starve_q;
    perr_d      = perr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    if_rvalid   = 1'b0;
    d_rvalid    = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if_gnt = sel_if_gnt;
        d_gnt  = sel_d_gnt;
        if (mem_rvalid) perr_d = 1'b1;
        if (sel_d_gnt) begin
          owner_d     = OWN_DATA;
          state_d     = ARB_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
          // A live fetch just lost; saturate so the counter never wraps.
          if (if_live && (starve_q != STARVE_W'(STARVE_LIMIT)))
            starve_d = starve_q + STARVE_W'(1);
        end else if (sel_if_gnt) begin
          owner_d     = OWN_IF;
          state_d     = ARB_REQ;
          starve_d    = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
        end
      end

      ARB_REQ: begin
        if (mem_rvalid) perr_d = 1'b1;
        if (if_flush && (owner_q == OWN_IF)) drop_d = 1'b1;
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = ARB_RESP;
        end
      end

      ARB_RESP: begin
        if (if_flush && (owner_q == OWN_IF)) drop_d = 1'b1;
        if (mem_rvalid) begin
          // A flush in the response cycle itself also kills the response.
          if_rvalid = (owner_q == OWN_IF) && !drop_q && !if_flush;
          d_rvalid  = (owner_q == OWN_DATA);
          state_d   = ARB_IDLE;
          owner_d   = OWN_NONE;
          drop_d    = 1'b0;
        end
      end

      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
        drop_d  = 1'b0;
      end
    endcase
  end

  assign if_rdata       = if_rvalid ? mem_rdata : '0;
  assign d_rdata        = d_rvalid  ? mem_rdata : '0;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_be         = mem_be_q;
  assign protocol_err   = perr_q;
  assign dbg_state      = state_q;
  assign dbg_owner      = owner_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_pl_rv32_mem_arbiter.sv
module tb_pl_rv32_mem_arbiter;
  import rv32_pipeline_pkg::*;

  localparam int LIMIT = 4;
  localparam logic [31:0] STORE_ACK = 32'hACCE_55ED;

  // ---------------- clock / reset / pins ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, if_gnt, if_rvalid;
  logic [31:0] if_addr = '0, if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_gnt, d_rvalid;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic [3:0]  d_be = '0;
  logic        mem_req, mem_we, mem_ready = 1'b0, mem_rvalid = 1'b0, protocol_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be, dbg_starve_cnt;
  logic [1:0]  dbg_state, dbg_owner;

  always #5 clk = ~clk;

  pl_rv32_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .protocol_err(protocol_err), .dbg_state(dbg_state), .dbg_owner(dbg_owner),
    .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- scoreboard storage ----------------
  typedef struct {
    logic        if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid, perr, we;
    logic [1:0]  state, owner;
    logic [3:0]  starve, be;
    logic [31:0] addr, wdata;
  } cyc_t;

  cyc_t        cyc_q[$];
  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memories (reference and environment) ----------------
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] env_mem[logic [31:0]];
  logic [31:0] env_addr = '0;
  logic        env_we = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction

  // ---------------- transaction-level reference model ----------------
  // One transaction at a time: granted, waits for acceptance, waits for
  // response. Arbitration follows the priority/starvation rule directly.
  logic        m_busy = 0, m_acc = 0, m_drop = 0, m_perr = 0, m_we = 0;
  int          m_owner = 0;  // 0 none, 1 fetch, 2 data
  int          m_starve = 0, m_req_cnt = 0, m_resp_cnt = 0;
  int          m_ready_dly = 0, m_rvalid_dly = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_exp_data = '0;
  logic [3:0]  m_be = '0;

  logic        if_pend = 0, d_pend = 0, dq_we = 0;
  logic [31:0] ifq_a = '0, dq_a = '0, dq_wd = '0;
  logic [3:0]  dq_be = '0;

  logic rand_mode = 0, force_flush_resp = 0, stray_now = 0, rst_now = 0;
  int   p_if = 0, p_d = 0, p_flush = 0, dir_ready_dly = 0, dir_rvalid_dly = 0;

  function automatic logic [31:0] rand_addr();
    return 32'h100 + 32'($urandom_range(0, 15)) * 4;
  endfunction

  task automatic start_txn();
    m_busy = 1; m_acc = 0; m_drop = 0; m_req_cnt = 0; m_resp_cnt = 0;
    m_ready_dly  = rand_mode ? int'($urandom_range(0, 3)) : dir_ready_dly;
    m_rvalid_dly = rand_mode ? int'($urandom_range(0, 3)) : dir_rvalid_dly;
  endtask

  task automatic cycle();
    cyc_t e;
    logic flush, eff_if, win_d, win_if;
    @(posedge clk);
    #1;
    if (!rst_now) begin
      if (!if_pend && ($urandom_range(0, 99) < p_if)) begin
        if_pend = 1; ifq_a = rand_addr();
      end
      if (!d_pend && ($urandom_range(0, 99) < p_d)) begin
        d_pend = 1; dq_we = 1'($urandom_range(0, 1)); dq_a = rand_addr();
        dq_wd = $urandom; dq_be = 4'($urandom_range(1, 15));
      end
    end
    flush = !rst_now && ($urandom_range(0, 99) < p_flush);
    if (force_flush_resp && m_busy && m_acc && m_owner == 1) begin
      flush = 1; force_flush_resp = 0;
    end

    e = '{default: '0};
    e.state  = !m_busy ? ARB_IDLE : (!m_acc ? ARB_REQ : ARB_RESP);
    e.owner  = (m_owner == 1) ? OWN_IF : ((m_owner == 2) ? OWN_DATA : OWN_NONE);
    e.starve = 4'(m_starve);
    e.perr   = m_perr;

    if_req = if_pend; if_addr = ifq_a; if_flush = flush;
    d_req = d_pend; d_we = dq_we; d_addr = dq_a; d_wdata = dq_wd; d_be = dq_be;
    mem_ready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_rvalid = 0;
    mem_rdata  = $urandom;

    if (rst_now) begin
      rst_n = 0; if_req = 0; d_req = 0; if_flush = 0; mem_ready = 0;
      if_pend = 0; d_pend = 0; m_busy = 0; m_acc = 0; m_drop = 0;
      m_owner = 0; m_starve = 0; m_perr = 0;
      e = '{default: '0};
      e.state = ARB_IDLE; e.owner = OWN_NONE;
    end else begin
      rst_n = 1;
      if (!m_busy) begin
        eff_if = if_pend && !flush;
        win_d  = d_pend && !(eff_if && m_starve == LIMIT);
        win_if = !win_d && eff_if;
        if (stray_now) begin mem_rvalid = 1; m_perr = 1; stray_now = 0; end
        if (win_d) begin
          e.d_gnt = 1;
          if (eff_if && m_starve < LIMIT) m_starve++;
          m_owner = 2; m_we = dq_we; m_addr = dq_a; m_wdata = dq_wd; m_be = dq_be;
          if (dq_we) begin
            ref_mem[dq_a] = merge(ref_rd(dq_a), dq_wd, dq_be);
            m_exp_data = STORE_ACK;
          end else m_exp_data = ref_rd(dq_a);
          d_pend = 0;
          start_txn();
        end else if (win_if) begin
          e.if_gnt = 1;
          m_starve = 0;
          m_owner = 1; m_we = 0; m_addr = ifq_a; m_wdata = '0; m_be = 4'hF;
          m_exp_data = ref_rd(ifq_a);
          if_pend = 0;
          start_txn();
        end
      end else if (!m_acc) begin
        e.mem_req = 1; e.we = m_we; e.addr = m_addr; e.wdata = m_wdata; e.be = m_be;
        if (flush && m_owner == 1) m_drop = 1;
        if (m_req_cnt >= m_ready_dly) begin
          mem_ready = 1; m_acc = 1;
        end else begin
          mem_ready = 0; m_req_cnt++;
        end
      end else begin
        if (flush && m_owner == 1) m_drop = 1;
        if (m_resp_cnt >= m_rvalid_dly) begin
          mem_rvalid = 1;
          mem_rdata  = env_we ? STORE_ACK : env_rd(env_addr);
          if (m_owner == 1 && !m_drop) begin e.if_rvalid = 1; if_exp_q.push_back(m_exp_data); end
          if (m_owner == 2) begin e.d_rvalid = 1; d_exp_q.push_back(m_exp_data); end
          m_busy = 0; m_drop = 0; m_owner = 0;
        end else m_resp_cnt++;
      end
    end
    cyc_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((m_busy || if_pend || d_pend) && n < 300) begin cycle(); n++; end
    if (n >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d cycles, expected < 300", n);
    end
    cycle();
  endtask

  // ---------------- monitor ----------------
  cyc_t mon_e;
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mon_e = cyc_q.pop_front();
      check("if_gnt", 32'(if_gnt), 32'(mon_e.if_gnt));
      check("d_gnt", 32'(d_gnt), 32'(mon_e.d_gnt));
      check("mem_req", 32'(mem_req), 32'(mon_e.mem_req));
      check("if_rvalid", 32'(if_rvalid), 32'(mon_e.if_rvalid));
      check("d_rvalid", 32'(d_rvalid), 32'(mon_e.d_rvalid));
      check("protocol_err", 32'(protocol_err), 32'(mon_e.perr));
      check("state", 32'(dbg_state), 32'(mon_e.state));
      check("owner", 32'(dbg_owner), 32'(mon_e.owner));
      check("starve_cnt", 32'(dbg_starve_cnt), 32'(mon_e.starve));
      if (mon_e.mem_req) begin
        check("mem_addr", mem_addr, mon_e.addr);
        check("mem_we", 32'(mem_we), 32'(mon_e.we));
        check("mem_wdata", mem_wdata, mon_e.wdata);
        check("mem_be", 32'(mem_be), 32'(mon_e.be));
      end
      if (if_rvalid) begin
        if (if_exp_q.size() == 0) check("if_rvalid_unexpected", 32'(if_rvalid), 32'd0);
        else check("if_rdata", if_rdata, if_exp_q.pop_front());
      end else check("if_rdata_gated", if_rdata, 32'd0);
      if (d_rvalid) begin
        if (d_exp_q.size() == 0) check("d_rvalid_unexpected", 32'(d_rvalid), 32'd0);
        else check("d_rdata", d_rdata, d_exp_q.pop_front());
      end else check("d_rdata_gated", d_rdata, 32'd0);
      // Environment memory takes the request as presented on the pins.
      if (rst_n && mem_req && mem_ready) begin
        env_addr = mem_addr;
        env_we   = mem_we;
        if (mem_we) env_mem[mem_addr] = merge(env_rd(mem_addr), mem_wdata, mem_be);
      end
    end
  end

  // ---------------- stimulus sequence ----------------
  initial begin
    ref_mem[32'h100] = 32'h0000_0013;
    env_mem[32'h100] = 32'h0000_0013;

    rst_now = 1; repeat (3) cycle(); rst_now = 0;

    // Lone fetch: accept on first mem_req cycle, response two cycles later.
    dir_ready_dly = 0; dir_rvalid_dly = 1;
    if_pend = 1; ifq_a = 32'h100;
    drain();

    // Store and fetch together: data first, fetch after the store completes.
    d_pend = 1; dq_we = 1; dq_a = 32'h2000; dq_wd = 32'hDEAD_BEEF; dq_be = 4'b0011;
    if_pend = 1; ifq_a = 32'h100;
    drain();

    // Continuous data pressure with a waiting fetch.
    p_if = 100; p_d = 100;
    repeat (40) cycle();
    p_if = 0; p_d = 0;
    drain();

    // Fetch flushed while waiting for its response, then a normal fetch.
    dir_rvalid_dly = 2; force_flush_resp = 1;
    if_pend = 1; ifq_a = 32'h104;
    drain();
    dir_rvalid_dly = 1;
    if_pend = 1; ifq_a = 32'h108;
    drain();

    // Slow memory: request held for seven cycles while both sides wait.
    dir_ready_dly = 6;
    if_pend = 1; ifq_a = 32'h10C;
    d_pend = 1; dq_we = 0; dq_a = 32'h2000; dq_wd = '0; dq_be = 4'hF;
    drain();
    dir_ready_dly = 0;

    // Randomized traffic with occasional flushes.
    rand_mode = 1; p_if = 40; p_d = 40; p_flush = 8;
    repeat (1500) cycle();
    p_if = 0; p_d = 0; p_flush = 0;
    drain();
    rand_mode = 0;

    // Stray response while idle: protocol_err sets and sticks.
    stray_now = 1; cycle();
    repeat (4) cycle();

    // Reset in the middle of a request phase.
    dir_ready_dly = 5;
    if_pend = 1; ifq_a = 32'h100;
    repeat (3) cycle();
    rst_now = 1; repeat (2) cycle(); rst_now = 0;
    dir_ready_dly = 0;
    repeat (2) cycle();
    if_pend = 1; ifq_a = 32'h110;
    drain();

    @(negedge clk);
    #1;
    check("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);
    check("if_queue_drained", 32'(if_exp_q.size()), 32'd0);
    check("d_queue_drained", 32'(d_exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
